// File: rtl/alu5_pkg.sv
// Shared types and helpers for the 5-bit ALU sequential multiplier.
package alu5_pkg;
    localparam int ALU_W  = 5;
    localparam int PROD_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [2:0] k;
        logic       carry;
    } dbg_t;

    // Partial product k: multiplicand shifted left by k when multiplier bit k is set.
    function automatic logic [PROD_W-1:0] partial_product(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input int               k
    );
        logic [PROD_W-1:0] ext;
        ext = {{(PROD_W-ALU_W){1'b0}}, a};
        partial_product = b[k] ? (ext << k) : '0;
    endfunction
endpackage

// File: rtl/add10_rca.sv
// 10-bit ripple-carry adder chained from fa cells.
module add10_rca
    import alu5_pkg::*;
(
    input  logic [PROD_W-1:0] A,
    input  logic [PROD_W-1:0] B,
    input  logic              CI,
    output logic [PROD_W-1:0] S,
    output logic              CO
);
    logic [PROD_W:0] carry;

    assign carry[0] = CI;

    for (genvar i = 0; i < PROD_W; i++) begin : g_bit
        fa u_fa (
            .a (A[i]),
            .b (B[i]),
            .ci(carry[i]),
            .s (S[i]),
            .co(carry[i+1])
        );
    end

    assign CO = carry[PROD_W];
endmodule

// File: rtl/fa.sv
// One-bit full adder cell, the building block of the ripple adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/mul5_seq_ctrl.sv
// Sequential 5x5 multiplier: one shared 10-bit adder walks the five partial products.
// Define MUL5_MAC_EN for multiply-accumulate mode (CLR input, sticky CO).
module mul5_seq_ctrl
    import alu5_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] P,
    output logic           CO,
    output logic           BUSY,
`ifdef MUL5_MAC_EN
    input  logic           CLR,
`endif
    output dbg_t           dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its data stay stable until that edge, ready may change freely.

    state_t           state, state_next;
    logic [CNT_W-1:0] k;
    logic [W-1:0]     a_q, b_q;
    logic [2*W-1:0]   acc, pp, sum;
    logic             add_co;

    assign pp = partial_product(a_q, b_q, int'(k));

    add10_rca u_add (
        .A (acc),
        .B (pp),
        .CI(1'b0),
        .S (sum),
        .CO(add_co)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (IN_VALID) state_next = ACC;
            ACC:     if (k == CNT_W'(W-1)) state_next = DONE;
            DONE:    if (OUT_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);
        BUSY      = (state != IDLE);
        P         = OUT_VALID ? acc : '0;
    end

`ifdef MUL5_MAC_EN
    logic co_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            co_q <= 1'b0;
        end else if (state == IDLE && IN_VALID && CLR) begin
            co_q <= 1'b0;
        end else if (state == ACC) begin
            co_q <= co_q | add_co;
        end
    end

    assign CO = co_q;
`else
    assign CO = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k   <= '0;
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (IN_VALID) begin
                    a_q <= A;
                    b_q <= B;
                    k   <= '0;
`ifdef MUL5_MAC_EN
                    // Accumulate onto the previous result unless cleared on this accept.
                    if (CLR) acc <= '0;
`else
                    acc <= '0;
`endif
                end
                ACC: begin
                    acc <= sum;
                    k   <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dbg = '{state: state, k: k, carry: add_co};
endmodule

// File: tb/tb_mul5_seq_ctrl.sv
// Directed bench for mul5_seq_ctrl with a product scoreboard; builds with or without MUL5_MAC_EN.
module tb_mul5_seq_ctrl;
    import alu5_pkg::*;

    logic       CLK = 1'b0;
    logic       RST, IN_VALID, OUT_READY, CLR;
    logic [4:0] A, B;
    logic       IN_READY, OUT_VALID, CO, BUSY;
    logic [9:0] P;
    dbg_t       dbg;

    int         checks = 0;
    int         errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] last_exp;
    logic [9:0]  model_acc = '0;
    logic        model_co  = 1'b0;

    always #5 CLK = ~CLK;

    mul5_seq_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .P        (P),
        .CO       (CO),
        .BUSY     (BUSY),
`ifdef MUL5_MAC_EN
        .CLR      (CLR),
`endif
        .dbg      (dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [4:0] a, input logic [4:0] b, input logic clr);
        logic [10:0] total;
        total = 11'(a) * 11'(b);
`ifdef MUL5_MAC_EN
        if (clr) begin
            model_acc = '0;
            model_co  = 1'b0;
        end
        total     = total + {1'b0, model_acc};
        model_co  = model_co | total[10];
        model_acc = total[9:0];
        exp_q.push_back({model_co, model_acc});
`else
        if (clr) model_acc = '0;
        exp_q.push_back({1'b0, total[9:0]});
`endif
    endtask

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic send(input logic [4:0] a, input logic [4:0] b, input logic clr, input bit hold);
        int n;
        n = 0;
        IN_VALID = 1'b1;
        A = a;
        B = b;
        CLR = clr;
        while (!IN_READY && n < 30) begin
            @(negedge CLK);
            n++;
        end
        check("accept_ready", IN_READY, 1);
        push_expected(a, b, clr);
        @(posedge CLK);
        #1;
        if (!hold) begin
            IN_VALID = 1'b0;
            A = 5'($urandom_range(0, 31));
            B = 5'($urandom_range(0, 31));
            CLR = 1'($urandom_range(0, 1));
        end
    endtask

    // Called just after the accepting edge; OUT_VALID must appear on the 6th edge.
    task automatic wait_result(input string tag);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check({tag, "_acc_flags"}, {OUT_VALID, BUSY, IN_READY}, 3'b010);
        end
        @(negedge CLK);
        check({tag, "_out_valid"}, OUT_VALID, 1);
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check({tag, "_p"}, P, last_exp[9:0]);
            check({tag, "_co"}, CO, last_exp[10]);
        end
    endtask

    initial begin
        RST = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        CLR = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge CLK);
        check("rst_in_ready", IN_READY, 1);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_p", P, 0);
        check("rst_co", CO, 0);
        check("rst_busy", BUSY, 0);
        RST = 1'b0;
        @(negedge CLK);

        send(5'd31, 5'd31, 1'b1, 1'b0);
        wait_result("t1_31x31");

        send(5'd0, 5'd31, 1'b1, 1'b0);
        wait_result("t2_0x31");
        send(5'd17, 5'd0, 1'b1, 1'b0);
        wait_result("t2_17x0");

        send(5'd13, 5'd11, 1'b1, 1'b0);
        OUT_READY = 1'b0;
        wait_result("t3_13x11");
        repeat (4) begin
            @(negedge CLK);
            check("t3_hold_valid", OUT_VALID, 1);
            check("t3_hold_p", P, last_exp[9:0]);
            check("t3_hold_in_ready", IN_READY, 0);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("t3_back_idle", dbg.state, IDLE);
        check("t3_in_ready", IN_READY, 1);

        send(5'd9, 5'd7, 1'b1, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("t4_k_before_abort", dbg.k, 2);
        RST = 1'b1;
        #1;
        check("t4_abort_out_valid", OUT_VALID, 0);
        check("t4_abort_busy", BUSY, 0);
        check("t4_abort_p", P, 0);
        void'(exp_q.pop_back());
        model_acc = '0;
        model_co = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send(5'd3, 5'd4, 1'b1, 1'b0);
        wait_result("t4_3x4");

        send(5'd6, 5'd5, 1'b1, 1'b1);
        A = 5'd2;
        B = 5'd3;
        wait_result("t5_6x5");
        @(negedge CLK);
        check("t5_second_in_idle", dbg.state, IDLE);
        push_expected(5'd2, 5'd3, 1'b1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        wait_result("t5_2x3");

        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
            wait_result("rand");
        end

`ifdef MUL5_MAC_EN
        @(negedge CLK);
        send(5'd31, 5'd31, 1'b1, 1'b0);
        wait_result("t6_first");
        send(5'd31, 5'd31, 1'b0, 1'b0);
        wait_result("t6_accum");
        check("t6_wrap_p", P, 898);
        check("t6_sticky_co", CO, 1);
        send(5'd2, 5'd2, 1'b1, 1'b0);
        wait_result("t6_clr");
`endif

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
